// File: rtl/l1_dcache_pkg.sv
// Shared types and address-field helpers for the L1 D-cache tag controller.
package l1_dcache_pkg;

  localparam int unsigned L1_ADDR_W   = 32;
  localparam int unsigned L1_TAG_W    = 20;
  localparam int unsigned L1_NUM_SETS = 64;
  localparam int unsigned L1_NUM_WAYS = 4;
  localparam int unsigned L1_IDX_W    = $clog2(L1_NUM_SETS);
  localparam int unsigned L1_WAY_W    = $clog2(L1_NUM_WAYS);
  localparam int unsigned L1_OFF_W    = L1_ADDR_W - L1_TAG_W - L1_IDX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    WAIT_FILL = 3'd3,
    UPDATE    = 3'd4,
    RESP      = 3'd5
  } state_e;

  function automatic logic [L1_TAG_W-1:0] get_tag(input logic [L1_ADDR_W-1:0] addr);
    return addr[L1_ADDR_W-1 -: L1_TAG_W];
  endfunction

  function automatic logic [L1_IDX_W-1:0] get_index(input logic [L1_ADDR_W-1:0] addr);
    return addr[L1_OFF_W +: L1_IDX_W];
  endfunction

endpackage

// File: rtl/l1_dcache_victim_sel.sv
// Replacement choice: lowest invalid way, otherwise the set's round-robin pointer.
module l1_dcache_victim_sel #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned WAY_W    = 2
) (
  input  logic [NUM_WAYS-1:0] line_valid_i,
  input  logic [WAY_W-1:0]    rr_ptr_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic                victim_was_valid_o
);

  // Scan from the top so the lowest invalid way is the last one written.
  always_comb begin
    victim_o           = rr_ptr_i;
    victim_was_valid_o = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      victim_o           = line_valid_i[w] ? victim_o : WAY_W'(w);
      victim_was_valid_o = victim_was_valid_o & line_valid_i[w];
    end
  end

endmodule

// File: rtl/l1_dcache_tag_ctrl.sv
// L1 D-cache tag sequencer: lookup, victim pick, line-fill request and tag write-back.
module l1_dcache_tag_ctrl
  import l1_dcache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TAG_W    = 20,
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic                                inv_all,
  output logic                                resp_valid,
  output logic                                resp_hit,
  output logic [$clog2(NUM_WAYS)-1:0]         resp_way,
  output logic                                multi_hit,
  output logic                                fill_req_valid,
  input  logic                                fill_req_ready,
  output logic [ADDR_W-1:0]                   fill_req_addr,
  input  logic                                fill_done,
  output logic                                ta_we,
  output logic [$clog2(NUM_SETS)-1:0]         ta_index,
  output logic [$clog2(NUM_WAYS)-1:0]         ta_way,
  output logic [TAG_W-1:0]                    ta_tag,
  input  logic [NUM_WAYS-1:0][TAG_W-1:0]      ta_tag_out,
  input  logic [NUM_WAYS-1:0]                 ta_valid_out
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned OFF_W = ADDR_W - TAG_W - IDX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [WAY_W-1:0]     victim_q;
  logic                 victim_valid_q;
  logic                 resp_hit_q;
  logic [WAY_W-1:0]     resp_way_q;
  logic                 multi_q;
  logic [NUM_WAYS-1:0]  ctrl_valid_q [NUM_SETS];
  logic [WAY_W-1:0]     rr_ptr_q [NUM_SETS];

  logic [IDX_W-1:0]     idx_s;
  logic [TAG_W-1:0]     tag_s;
  logic [NUM_WAYS-1:0]  line_valid_s;
  logic [NUM_WAYS-1:0]  match_s;
  logic [WAY_W-1:0]     hit_way_s;
  logic                 multi_s;
  logic [WAY_W-1:0]     victim_s;
  logic                 victim_was_valid_s;

  assign idx_s        = addr_q[OFF_W +: IDX_W];
  assign tag_s        = addr_q[ADDR_W-1 -: TAG_W];
  assign line_valid_s = ctrl_valid_q[idx_s] & ta_valid_out;

  // Tag compare; the lowest matching way is reported, more than one match flags an error.
  always_comb begin
    hit_way_s = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      match_s[w] = line_valid_s[w] && (ta_tag_out[w] == tag_s);
      hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
    end
    multi_s = ($countones(match_s) > 32'd1);
  end

  l1_dcache_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim_sel (
    .line_valid_i       (line_valid_s),
    .rr_ptr_i           (rr_ptr_q[idx_s]),
    .victim_o           (victim_s),
    .victim_was_valid_o (victim_was_valid_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = (req_valid && req_ready) ? LOOKUP : IDLE;
      LOOKUP:    state_d = (|match_s) ? RESP : MISS_REQ;
      MISS_REQ:  state_d = fill_req_ready ? WAIT_FILL : MISS_REQ;
      WAIT_FILL: state_d = fill_done ? UPDATE : WAIT_FILL;
      UPDATE:    state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    fill_req_valid = 1'b0;
    ta_we          = 1'b0;
    case (state_q)
      IDLE:     req_ready      = rst_n & ~inv_all;
      MISS_REQ: fill_req_valid = 1'b1;
      UPDATE:   ta_we          = 1'b1;
      RESP:     resp_valid     = 1'b1;
      default:  req_ready      = 1'b0;
    endcase
    multi_hit = resp_valid & multi_q;
  end

  assign resp_hit      = resp_hit_q;
  assign resp_way      = resp_way_q;
  assign fill_req_addr = addr_q & LINE_MASK;
  assign ta_index      = idx_s;
  assign ta_way        = victim_q;
  assign ta_tag        = tag_s;

  // Request latch and lookup/fill result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      victim_q       <= '0;
      victim_valid_q <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_way_q     <= '0;
      multi_q        <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid && req_ready) begin
        addr_q <= req_addr;
      end
      if (state_q == LOOKUP) begin
        resp_hit_q     <= |match_s;
        resp_way_q     <= hit_way_s;
        multi_q        <= multi_s;
        victim_q       <= victim_s;
        victim_valid_q <= victim_was_valid_s;
      end else if (state_q == UPDATE) begin
        resp_hit_q <= 1'b0;
        resp_way_q <= victim_q;
        multi_q    <= 1'b0;
      end
    end
  end

  // Authoritative valid bits and per-set replacement pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        ctrl_valid_q[s] <= '0;
        rr_ptr_q[s]     <= '0;
      end
    end else if (state_q == IDLE && inv_all) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        ctrl_valid_q[s] <= '0;
      end
    end else if (state_q == UPDATE) begin
      ctrl_valid_q[idx_s][victim_q] <= 1'b1;
      if (victim_valid_q) begin
        rr_ptr_q[idx_s] <= victim_q + WAY_W'(1);
      end
    end
  end

endmodule
